ram_stream_port: RTL and testbench
==================================

# ram_stream_port

Initiator-side access controller for the team's single-port RAM (synchronous write, combinational read). Accepts one command at a time, either a fill (stream words into consecutive RAM addresses) or a drain (stream words out of consecutive RAM addresses), and drives the RAM's `we`/`a`/`di` pins while reading its `do` pin. It sits between the DSP datapath's valid/ready streams and the coefficient/sample RAM, so no other block ever drives RAM pins directly.

## Interface
- `ADDR_WIDTH`, 6: RAM address width; RAM depth is 2**ADDR_WIDTH words.
- `DATA_WIDTH`, 16: word width (signed two's-complement data, passed through unmodified).

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_write`  in  1  1 = fill, 0 = drain.
- `cmd_base`  in  ADDR_WIDTH  first RAM address.
- `cmd_len`  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH.
- `s_valid` / `s_ready` / `s_data`  in/out/in  1/1/DATA_WIDTH  fill stream.
- `m_valid` / `m_ready` / `m_data` / `m_last`  out/in/out/out  1/1/DATA_WIDTH/1  drain stream.
- `done`  out  1  one-cycle pulse at command completion.
- `ram_we`  out  1  RAM write enable.
- `ram_a`  out  ADDR_WIDTH  RAM address.
- `ram_di`  out  DATA_WIDTH  RAM write data.
- `ram_do`  in  DATA_WIDTH  RAM combinational read data.

## Operation
- States: IDLE, FILL, DRAIN, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch base, len, clear offset counter; go FILL or DRAIN per `cmd_write`; len = 0 goes straight to DONE.
- Address: `ram_a` = (base + offset) mod 2**ADDR_WIDTH; wraps from all-ones to 0 with no error.
- FILL: `s_ready`=1; `ram_we` = `s_valid` (combinational); `ram_di` = `s_data`. Each `s_valid` cycle writes one word at that edge and increments offset. After the beat with offset = len-1, go DONE.
- DRAIN: one-entry output register holding `m_data`/`m_last`. Register loads `ram_do` when empty or when current beat handshakes (`m_valid & m_ready`) and words remain to fetch; offset increments per load. `m_last`=1 on the word at offset len-1. After the `m_last` beat handshakes, go DONE. `m_data` holds stable while `m_valid & !m_ready`.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `ram_we`=0 and `s_ready`=0 in every state except FILL; `m_valid`=0 outside DRAIN.
- Commands offered while busy are not accepted (`cmd_ready`=0); no queueing.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `s_ready`=0, `ram_we`=0, `ram_a`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `done`=0.
- Command accepted at edge T; FILL/DRAIN entered at T.
- Fill: first write at edge T+1 if `s_valid`; throughput 1 word/cycle; `done` in cycle after final write edge.
- Drain: first `m_valid` in cycle T+2 (one register stage); sustained 1 word/cycle with `m_ready` held high; `done` in cycle after the `m_last` handshake.
- Len 0: `done` pulse in cycle T+1, no RAM access, no stream beats.
- Full length 2**ADDR_WIDTH: every address touched exactly once, wrapping through 0.
- Reset asserted mid-command: outputs return to reset values immediately (asynchronous); partial writes already committed remain in RAM; no `done`.

## Structure
- Package `ram_port_pkg`: state enum (IDLE, FILL, DRAIN, DONE), command opcode constants (`CMD_DRAIN`=0, `CMD_FILL`=1).
- Sub-module `ram_addr_gen`: latched base, offset counter with clear/increment, wrapped address output, `is_last` flag (offset == len-1).

## Test plan
- Fill base=0, len=4, data 0x0001..0x0004 with `s_valid` continuous -> RAM[0..3]=1..4, `done` pulse one cycle after fourth write, `ram_we` never high afterwards.
- Drain base=0, len=4, `m_ready`=1 -> `m_data` 1,2,3,4 on consecutive cycles starting T+2, `m_last` only with 4, `done` next cycle.
- Drain with `m_ready` toggling 1,0,0,1,... -> `m_data` stable during stalls, no word lost or repeated, order 1..4.
- Fill base=62, len=4 (ADDR_WIDTH=6), data 0xA0..0xA3 -> RAM[62]=0xA0, [63]=0xA1, [0]=0xA2, [1]=0xA3; drain same range returns identical sequence.
- Len=0 command -> `done` at T+1, no `ram_we`, no `m_valid`; `cmd_valid` held during busy -> second command accepted only after return to IDLE.
- Assert `rst_n`=0 after two of four fill beats -> `ram_we`, `s_ready` drop immediately, no `done`; RAM[0..1] written, RAM[2..3] unchanged; next command runs normally.

Source files
------------

// File: rtl/ram_stream_port_pkg.sv
// Shared types for the RAM stream port: controller states and command opcodes.
// Pure declarations; no logic, no latency.
package ram_port_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic CMD_DRAIN = 1'b0;
  localparam logic CMD_FILL  = 1'b1;

endpackage

// File: rtl/ram_stream_port_if.sv
// Command, fill/drain stream and RAM pin bundle of the RAM stream port.
// slave = controller view, master = datapath/RAM view.
interface ram_stream_port_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_base;
  logic [ADDR_WIDTH:0]   cmd_len;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  done;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic [DATA_WIDTH-1:0] ram_di;
  logic [DATA_WIDTH-1:0] ram_do;

  modport slave (
    input  cmd_valid, cmd_write, cmd_base, cmd_len, s_valid, s_data, m_ready, ram_do,
    output cmd_ready, s_ready, m_valid, m_data, m_last, done, ram_we, ram_a, ram_di
  );

  modport master (
    output cmd_valid, cmd_write, cmd_base, cmd_len, s_valid, s_data, m_ready, ram_do,
    input  cmd_ready, s_ready, m_valid, m_data, m_last, done, ram_we, ram_a, ram_di
  );

endinterface

// File: rtl/ram_stream_port_addr_gen.sv
// Address generator: latched base plus offset counter, wrapped to RAM depth.
// Address is combinational from registered state; is_last flags offset == len-1.
module ram_addr_gen #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] base_in,
  input  logic [ADDR_WIDTH:0]   len_in,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  is_last
);

  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   offset_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      len_q    <= '0;
      offset_q <= '0;
    end else if (load) begin
      base_q   <= base_in;
      len_q    <= len_in;
      offset_q <= '0;
    end else if (inc) begin
      offset_q <= offset_q + ONE;
    end
  end

  // Offset is one bit wider than the address so a full-depth run can count to 2**ADDR_WIDTH.
  assign addr    = base_q + offset_q[ADDR_WIDTH-1:0];
  assign is_last = (offset_q == (len_q - ONE));

endmodule

// File: rtl/ram_stream_port.sv
// Single-command fill/drain controller for the single-port coefficient/sample RAM.
// Fill writes 1 word/cycle as s_valid arrives; drain has one output register stage.
module ram_stream_port
  import ram_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_stream_port_if.slave bus
);

  state_t state_q, state_d;

  logic                  accept;
  logic                  fill_beat;
  logic                  handshake;
  logic                  drain_load;
  logic                  is_last;
  logic [ADDR_WIDTH-1:0] addr;

  logic                  fetch_q;
  logic                  m_valid_q;
  logic                  m_last_q;
  logic [DATA_WIDTH-1:0] m_data_q;

  logic cmd_ready_c;
  logic s_ready_c;
  logic done_c;

  assign accept     = (state_q == IDLE) && bus.cmd_valid;
  assign fill_beat  = (state_q == FILL) && bus.s_valid;
  assign handshake  = m_valid_q && bus.m_ready;
  // Refill the output register whenever it is empty or being emptied this cycle.
  assign drain_load = (state_q == DRAIN) && fetch_q && (!m_valid_q || handshake);

  ram_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .inc     (fill_beat || drain_load),
    .base_in (bus.cmd_base),
    .len_in  (bus.cmd_len),
    .addr    (addr),
    .is_last (is_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_c = 1'b0;
    s_ready_c   = 1'b0;
    done_c      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          if (bus.cmd_len == '0) begin
            state_d = DONE;
          end else if (bus.cmd_write == CMD_FILL) begin
            state_d = FILL;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      FILL: begin
        s_ready_c = 1'b1;
        if (fill_beat && is_last) begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (handshake && m_last_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      if (accept) begin
        fetch_q <= 1'b1;
      end else if (drain_load && is_last) begin
        fetch_q <= 1'b0;
      end

      if (drain_load) begin
        m_valid_q <= 1'b1;
        m_data_q  <= bus.ram_do;
        m_last_q  <= is_last;
      end else if (handshake) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.s_ready   = s_ready_c;
  assign bus.done      = done_c;
  assign bus.ram_we    = fill_beat;
  assign bus.ram_a     = addr;
  assign bus.ram_di    = bus.s_data;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_last    = m_last_q && m_valid_q;

endmodule

// File: tb/tb_ram_stream_port.sv
// Bench for ram_stream_port: behavioural RAM, reference memory image and a drain scoreboard.
module tb_ram_stream_port;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst_n;

  ram_stream_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_stream_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural single-port RAM: synchronous write, combinational read, preloaded once.
  logic [DW-1:0] mem [DEPTH];
  bit            loaded;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'hC000 + 16'(i);
      loaded <= 1'b1;
    end else if (bus.ram_we) begin
      mem[bus.ram_a] <= bus.ram_di;
    end
  end

  assign bus.ram_do = mem[bus.ram_a];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW:0]   exp_q [$];
  int            n_chk;
  int            n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_ram(input string tag);
    for (int a = 0; a < DEPTH; a++) chk(tag, 32'(mem[a]), 32'(exp_mem[a]));
  endtask

  task automatic do_fill(input int base, input int len, input logic [DW-1:0] d0, input int step);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_base  = AW'(base);
    bus.cmd_len   = (AW+1)'(len);
    #1 chk("fill_cmd_ready", 32'(bus.cmd_ready), 1);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      // Keep offering a drain while busy; it must not be taken until IDLE.
      bus.cmd_write = 1'b0;
      bus.cmd_valid = (i != len - 1);
      bus.s_valid   = 1'b1;
      bus.s_data    = d0 + DW'(i * step);
      exp_mem[(base + i) % DEPTH] = d0 + DW'(i * step);
      #1;
      chk("fill_busy_cmd_ready", 32'(bus.cmd_ready), 0);
      chk("fill_s_ready", 32'(bus.s_ready), 1);
      chk("fill_we", 32'(bus.ram_we), 1);
      chk("fill_addr", 32'(bus.ram_a), 32'((base + i) % DEPTH));
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    #1;
    chk("fill_done", 32'(bus.done), 1);
    chk("fill_done_we", 32'(bus.ram_we), 0);
    chk("fill_done_s_ready", 32'(bus.s_ready), 0);
    @(negedge clk);
    #1;
    chk("fill_done_pulse", 32'(bus.done), 0);
    chk("fill_idle_ready", 32'(bus.cmd_ready), 1);
    chk("fill_idle_we", 32'(bus.ram_we), 0);
  endtask

  // mode 0: m_ready always high, 1: pattern 1,0,0 repeating, 2: random.
  task automatic do_drain(input int base, input int len, input int mode, input bit timing);
    int            cyc;
    int            hs_cnt;
    int            first_vld;
    bit            stalled;
    logic [DW-1:0] held;
    logic [DW:0]   e;
    cyc       = 0;
    hs_cnt    = 0;
    first_vld = -1;
    stalled   = 1'b0;
    held      = '0;
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), exp_mem[(base + i) % DEPTH]});
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_base  = AW'(base);
    bus.cmd_len   = (AW+1)'(len);
    #1 chk("drn_cmd_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cyc = 1;
    while (hs_cnt < len && cyc < 400) begin
      case (mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = ((cyc + 1) % 3 == 0);
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (stalled) begin
        chk("drn_hold_valid", 32'(bus.m_valid), 1);
        chk("drn_hold_data", 32'(bus.m_data), 32'(held));
      end
      stalled = 1'b0;
      if (bus.m_valid) begin
        if (first_vld < 0) first_vld = cyc;
        if (bus.m_ready) begin
          if (exp_q.size() == 0) begin
            chk("drn_extra_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("drn_data", 32'(bus.m_data), 32'(e[DW-1:0]));
            chk("drn_last", 32'(bus.m_last), 32'(e[DW]));
          end
          hs_cnt++;
        end else begin
          stalled = 1'b1;
          held    = bus.m_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (hs_cnt < len) begin
      chk("drn_timeout", 32'(hs_cnt), 32'(len));
      exp_q.delete();
    end
    bus.m_ready = 1'b0;
    #1;
    chk("drn_done", 32'(bus.done), 1);
    chk("drn_done_valid", 32'(bus.m_valid), 0);
    if (timing) begin
      chk("drn_first_valid_cyc", 32'(first_vld), 2);
      if (mode == 0) chk("drn_done_cyc", 32'(cyc), 32'(len + 2));
    end
    @(negedge clk);
    #1;
    chk("drn_done_pulse", 32'(bus.done), 0);
    chk("drn_idle_ready", 32'(bus.cmd_ready), 1);
  endtask

  initial begin
    logic [DW:0] e;
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 16'hC000 + 16'(i);
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.m_ready   = 1'b0;

    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    chk("rst_we", 32'(bus.ram_we), 0);
    chk("rst_addr", 32'(bus.ram_a), 0);
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_m_last", 32'(bus.m_last), 0);
    chk("rst_m_data", 32'(bus.m_data), 0);
    chk("rst_done", 32'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_fill(0, 4, 16'h0001, 1);
    check_ram("ram_fill0");
    do_drain(0, 4, 0, 1'b1);
    do_drain(0, 4, 1, 1'b1);

    do_fill(62, 4, 16'h00A0, 1);
    check_ram("ram_fill_wrap");
    do_drain(62, 4, 0, 1'b1);

    // Zero-length command, with a drain offered back-to-back behind it.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_base  = AW'(9);
    bus.cmd_len   = '0;
    #1 chk("len0_cmd_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    bus.cmd_write = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = (AW+1)'(1);
    #1;
    chk("len0_done", 32'(bus.done), 1);
    chk("len0_we", 32'(bus.ram_we), 0);
    chk("len0_m_valid", 32'(bus.m_valid), 0);
    chk("len0_busy_ready", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    exp_q.push_back({1'b1, exp_mem[0]});
    #1;
    chk("len0_done_pulse", 32'(bus.done), 0);
    chk("held_cmd_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.m_ready   = 1'b1;
    #1;
    chk("held_busy_ready", 32'(bus.cmd_ready), 0);
    chk("held_m_valid_t1", 32'(bus.m_valid), 0);
    @(negedge clk);
    #1;
    chk("held_m_valid_t2", 32'(bus.m_valid), 1);
    e = exp_q.pop_front();
    chk("held_data", 32'(bus.m_data), 32'(e[DW-1:0]));
    chk("held_last", 32'(bus.m_last), 32'(e[DW]));
    @(negedge clk);
    bus.m_ready = 1'b0;
    #1;
    chk("held_done", 32'(bus.done), 1);
    chk("held_done_valid", 32'(bus.m_valid), 0);

    // Reset during the third beat of a four-word fill.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_base  = '0;
    bus.cmd_len   = (AW+1)'(4);
    #1 chk("rstmid_cmd_ready", 32'(bus.cmd_ready), 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.s_valid   = 1'b1;
      bus.s_data    = 16'h0050 + 16'(i);
      exp_mem[i]    = 16'h0050 + 16'(i);
      #1 chk("rstmid_we", 32'(bus.ram_we), 1);
    end
    @(negedge clk);
    bus.s_data = 16'h0052;
    #1 chk("rstmid_we_pre", 32'(bus.ram_we), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_we_drop", 32'(bus.ram_we), 0);
    chk("rstmid_s_ready_drop", 32'(bus.s_ready), 0);
    chk("rstmid_done", 32'(bus.done), 0);
    chk("rstmid_addr", 32'(bus.ram_a), 0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    #1 chk("rstmid_done_hold", 32'(bus.done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmid_after_done", 32'(bus.done), 0);
    chk("rstmid_after_ready", 32'(bus.cmd_ready), 1);
    check_ram("ram_rstmid");
    do_drain(0, 4, 2, 1'b1);

    do_fill(5, DEPTH, 16'h0100, 7);
    check_ram("ram_full");
    do_drain(5, DEPTH, 2, 1'b1);
    do_drain(5, DEPTH, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
